// File: rtl/loader_pkg.sv
// Shared types and sizing for the boot-time instruction memory loader.
package loader_pkg;

  localparam int LOADER_DATA_W = 8;
  localparam int LOADER_DEPTH  = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

  // States in which the loader consumes stream bytes.
  function automatic logic state_accepts(input loader_state_t s);
    logic v;
    case (s)
      ST_LEN, ST_DATA, ST_CSUM: v = 1'b1;
      default:                  v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Framed byte-stream loader (length, payload, checksum) that writes the
// instruction memory from address 0 while holding the core in reset.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int DATA_W = LOADER_DATA_W,
  parameter int DEPTH  = LOADER_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  // One extra bit so a count of DEPTH is representable without wrapping.
  localparam int                CNT_W   = ADDR_W + 1;
  localparam logic [DATA_W-1:0] DEPTH_D = DATA_W'(DEPTH);

  loader_state_t     r_state;
  loader_state_t     w_next_state;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_sum;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic [CNT_W-1:0]  w_len;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_inc;
  logic [DATA_W-1:0] w_sum;
  logic              w_in_ready;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_cpu_hold;
  logic              w_busy;
  logic              w_done;
  logic              w_error;
  logic              w_accept;

  assign w_accept    = i_in_valid && r_in_ready;
  assign w_count_inc = r_count + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, counter, checksum and output-register values.
  always_comb begin
    w_next_state = r_state;
    w_len        = r_len;
    w_count      = r_count;
    w_sum        = r_sum;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_cpu_hold   = r_cpu_hold;
    w_busy       = r_busy;
    w_done       = r_done;
    w_error      = r_error;

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          w_next_state = ST_LEN;
          w_cpu_hold   = 1'b1;
          w_busy       = 1'b1;
          w_done       = 1'b0;
          w_error      = 1'b0;
          w_count      = '0;
          w_sum        = '0;
        end else begin
          w_next_state = r_state;
        end
      end
      ST_LEN: begin
        if (w_accept) begin
          if ((i_in_data == '0) || (i_in_data > DEPTH_D)) begin
            // Rejected frame: keep the core held, nothing is written.
            w_next_state = ST_ERR;
            w_error      = 1'b1;
            w_busy       = 1'b0;
          end else begin
            w_next_state = ST_DATA;
            w_len        = CNT_W'(i_in_data);
          end
        end else begin
          w_next_state = ST_LEN;
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_count[ADDR_W-1:0];
          w_mem_wdata = i_in_data;
          w_sum       = r_sum + i_in_data;
          w_count     = w_count_inc;
          if (w_count_inc == r_len) begin
            w_next_state = ST_CSUM;
          end else begin
            w_next_state = ST_DATA;
          end
        end else begin
          w_next_state = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          w_busy = 1'b0;
          if (i_in_data == r_sum) begin
            w_next_state = ST_DONE;
            w_done       = 1'b1;
            w_cpu_hold   = 1'b0;
          end else begin
            // Corrupt image: core stays in reset until a new load.
            w_next_state = ST_ERR;
            w_error      = 1'b1;
          end
        end else begin
          w_next_state = ST_CSUM;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    w_in_ready = state_accepts(w_next_state);
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len       <= '0;
      r_count     <= '0;
      r_sum       <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_len       <= w_len;
      r_count     <= w_count;
      r_sum       <= w_sum;
      r_in_ready  <= w_in_ready;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_cpu_hold  <= w_cpu_hold;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_error     <= w_error;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time program loader that writes the byte-wide instruction memory, which the processor core otherwise only reads. It accepts a framed byte stream over a valid/ready handshake, consisting of a length byte, the payload bytes and a checksum byte. Payload bytes are written to consecutive instruction-memory addresses from 0 while the core is held in reset. It sits beside the microprocessor top and shares that memory's address/wdata/we port through a mux selected by `cpu_hold`.

## Interface
- `DATA_W`, default 8: stream and memory data width.
- `DEPTH`, default 64: instruction memory entries; the largest legal length value.
- `ADDR_W`, default `$clog2(DEPTH)`: memory address width.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to begin a load.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  DATA_W  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  1 = write strobe to instruction memory, one cycle per byte.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `cpu_hold`  out  1  holds the core in reset and selects the loader onto the memory port.
- `busy`  out  1  load in progress.
- `done`  out  1  last load succeeded; sticky.
- `error`  out  1  last load failed; sticky.

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- Reset state is IDLE. Reset values:
  - `in_ready`, `mem_we`, `cpu_hold`, `busy`, `done`, `error` = 0.
  - `mem_addr`, `mem_wdata` = 0.
  - Internal count and sum = 0.
- A byte is accepted on a cycle where `in_valid && in_ready`.
- `in_ready` = 1 exactly in LEN, DATA and CSUM.
- IDLE, DONE or ERR with `start`=1:
  - go to LEN.
  - `cpu_hold`=1 and `busy`=1.
  - clear `done`, `error`, count and sum.
- `start` is ignored while in LEN, DATA or CSUM.
- LEN accept: latch L = `in_data`.
  - L = 0 or L > DEPTH → ERR. No writes.
  - Otherwise → DATA.
- DATA accept:
  - write the byte at address = count.
  - sum ← sum + byte, mod 2^DATA_W.
  - count increments.
  - After the accept where count reaches L → CSUM.
- CSUM accept:
  - `in_data` == sum → DONE: `done`=1, `cpu_hold`=0, `busy`=0.
  - Otherwise → ERR: `error`=1, `busy`=0, `cpu_hold` stays 1 so the core never runs a corrupt image.
- ERR is left only by `start` or `rst`.
- Memory beyond address L−1 is never written.
- Reset mid-load:
  - return to IDLE with all outputs at reset values.
  - Memory keeps the partial contents; no clean-up writes.

## Timing
- Write latency: `mem_we`, `mem_addr`, `mem_wdata` are registered and asserted the cycle after the DATA accept. `mem_we` is high for exactly one cycle per byte.
- Back-to-back accepts give back-to-back writes, one byte per cycle sustained.
- `in_ready` is registered from the state. It goes high the cycle after `start` and drops the cycle after the CSUM accept, or after a rejected LEN.
- `done`/`error` are set, and `cpu_hold` released on success, in the cycle after the CSUM accept. The final data write has completed by then.
- `in_valid` may stall any number of cycles; state, count and sum hold while no accept occurs.
- `rst` and `start` in the same cycle: `rst` wins.
- L = DEPTH is legal. The last write goes to address DEPTH−1 and the counter does not wrap into address 0.

## Structure
- Shared package `loader_pkg`:
  - state enum `loader_state_t`.
  - constants `LOADER_DATA_W`=8 and `LOADER_DEPTH`=64, matching the instruction memory.
- Single module; no sub-module needed. Counter, checksum accumulator and FSM are small enough to live together.
- The memory port mux (loader vs. core, selected by `cpu_hold`) belongs in the microprocessor top, not in this block.

## Test plan
- Normal load:
  - Stimulus: `start`, then bytes 0x04, 0x11, 0x22, 0x33, 0x44, 0xAA, all with `in_valid` held high.
  - Required: four `mem_we` pulses at addresses 0..3 with those data on consecutive cycles; `done`=1, `cpu_hold`=0; memory reads back 11/22/33/44.
- Bad checksum:
  - Stimulus: same frame with a checksum byte of 0xAB.
  - Required: four writes occur, then `error`=1, `cpu_hold`=1, `done`=0, `in_ready`=0.
- Illegal length:
  - Stimulus: length 0x00, then separately length 0x41 (65).
  - Required: in both cases ERR with zero `mem_we` pulses.
- Stalls and full depth:
  - Stimulus: L=64 with random `in_valid` gaps.
  - Required: exactly 64 writes at addresses 0..63 in order, no write at 0 after 63; correct checksum gives `done`=1.
- Reset mid-load:
  - Stimulus: `rst` after the 2nd payload byte of an L=4 load.
  - Required: the next cycle shows all outputs at reset values and no further writes; a following `start` with a full frame loads correctly.
- Restart from DONE/ERR:
  - Stimulus: `start` in ERR, and separately `start` while in DATA.
  - Required: in ERR, `error` clears and `in_ready` rises one cycle later; in DATA, the start is ignored and the load continues unaffected.
